// File: rtl/dramsim3_channel_mem.sv
// Per-channel backing store for a DRAM timing model.
// Maps channel-local byte addresses into the global address space by inserting
// the channel-select bits, unmaps completed-read addresses back, and holds the
// channel's words in a 1-read/1-write synchronous memory.
module dramsim3_channel_mem #(
  parameter int unsigned channel_addr_width_p = 16,
  parameter int unsigned data_width_p         = 32,
  parameter int unsigned num_channels_p       = 2,
  parameter int unsigned num_columns_p        = 8,
  parameter int unsigned address_mapping_p    = 0,
  parameter int unsigned channel_select_p     = 0,
  parameter int unsigned init_mem_p           = 1,
  localparam int unsigned k_lp = (num_channels_p > 2) ? $clog2(num_channels_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [channel_addr_width_p-1:0]      ch_addr_i,
  output logic [channel_addr_width_p+k_lp-1:0] mem_addr_o,
  input  logic                                 w_v_i,
  input  logic [data_width_p-1:0]              w_data_i,
  input  logic                                 rd_v_i,
  input  logic [channel_addr_width_p+k_lp-1:0] rd_mem_addr_i,
  output logic                                 data_v_o,
  output logic [data_width_p-1:0]              data_o,
  output logic [channel_addr_width_p-1:0]      read_done_ch_addr_o,
  output logic                                 ch_mismatch_o
);

  localparam int unsigned w_lp     = channel_addr_width_p;
  localparam int unsigned d_lp     = data_width_p;
  localparam int unsigned b_lp     = $clog2(d_lp / 8);
  localparam int unsigned c_lp     = $clog2(num_columns_p);
  localparam int unsigned mw_lp    = w_lp + k_lp;
  localparam int unsigned idx_w_lp = w_lp - b_lp;
  localparam int unsigned depth_lp = 1 << idx_w_lp;

  // Bit position where the channel field sits inside the mapped address.
  // Unknown mapping values fall back to "channel above column".
  localparam int unsigned shift_lp = (address_mapping_p == 1) ? w_lp :
                                     (address_mapping_p == 2) ? b_lp :
                                                                b_lp + c_lp;

  // Channel-address bits that stay below the channel field.
  localparam logic [mw_lp-1:0] low_mask_lp = (mw_lp'(1) << shift_lp) - mw_lp'(1);
  localparam logic [k_lp-1:0]  ch_lp       = k_lp'(channel_select_p);
  localparam logic [d_lp-1:0]  init_word_lp = (init_mem_p != 0) ? {d_lp{1'b0}}
                                                                : {d_lp{1'bx}};

  logic [mw_lp-1:0]    req_ext;
  logic [w_lp-1:0]     rd_ch_addr;
  logic [k_lp-1:0]     rd_ch_field;
  logic [idx_w_lp-1:0] rd_idx;
  logic [idx_w_lp-1:0] wr_idx;

  // Word storage; power-up contents selected by init_mem_p, untouched by reset.
  logic [d_lp-1:0] mem_r [depth_lp] = '{default: init_word_lp};

  // Forward map: split the channel address at shift_lp and insert the channel bits.
  always_comb begin
    req_ext    = mw_lp'(ch_addr_i);
    mem_addr_o = ((req_ext & ~low_mask_lp) << k_lp)
               | (mw_lp'(ch_lp) << shift_lp)
               | (req_ext & low_mask_lp);
  end

  // Inverse map: drop the channel field and close the gap; also extract the field.
  always_comb begin
    rd_ch_addr  = w_lp'(((rd_mem_addr_i >> k_lp) & ~low_mask_lp)
                       | (rd_mem_addr_i & low_mask_lp));
    rd_ch_field = k_lp'(rd_mem_addr_i >> shift_lp);
    rd_idx      = rd_ch_addr[w_lp-1:b_lp];
    wr_idx      = ch_addr_i[w_lp-1:b_lp];
  end

  // Write port; requests presented during reset are dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i && w_v_i) begin
      mem_r[wr_idx] <= w_data_i;
    end
  end

  // Read response register; same-cycle write to the same word returns old data.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      data_v_o            <= 1'b0;
      data_o              <= '0;
      read_done_ch_addr_o <= '0;
      ch_mismatch_o       <= 1'b0;
    end else begin
      data_v_o      <= rd_v_i;
      ch_mismatch_o <= rd_v_i & (rd_ch_field != ch_lp);
      if (rd_v_i) begin
        data_o              <= mem_r[rd_idx];
        read_done_ch_addr_o <= rd_ch_addr;
      end
    end
  end

endmodule

// File: tb/tb_dramsim3_channel_mem.sv
// Scoreboard bench for dramsim3_channel_mem (W=16, D=32, channel 1 of 2).
// Main instance uses mapping mode 0; two side instances cover modes 1 and 2.
module tb_dramsim3_channel_mem;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] ch_addr_i;
  logic        w_v_i;
  logic [31:0] w_data_i;
  logic        rd_v_i;
  logic [16:0] rd_mem_addr_i;

  logic [16:0] mem_addr0, mem_addr1, mem_addr2;
  logic        data_v0, data_v1, data_v2;
  logic [31:0] data0, data1, data2;
  logic [15:0] rdaddr0, rdaddr1, rdaddr2;
  logic        mism0, mism1, mism2;

  logic        rv1, rv2;
  logic [16:0] ra1, ra2;

  always #5 clk = ~clk;

  dramsim3_channel_mem #(.address_mapping_p(0), .channel_select_p(1)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .ch_addr_i(ch_addr_i), .mem_addr_o(mem_addr0),
    .w_v_i(w_v_i), .w_data_i(w_data_i), .rd_v_i(rd_v_i), .rd_mem_addr_i(rd_mem_addr_i),
    .data_v_o(data_v0), .data_o(data0), .read_done_ch_addr_o(rdaddr0), .ch_mismatch_o(mism0));

  dramsim3_channel_mem #(.address_mapping_p(1), .channel_select_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .ch_addr_i(ch_addr_i), .mem_addr_o(mem_addr1),
    .w_v_i(w_v_i), .w_data_i(w_data_i), .rd_v_i(rv1), .rd_mem_addr_i(ra1),
    .data_v_o(data_v1), .data_o(data1), .read_done_ch_addr_o(rdaddr1), .ch_mismatch_o(mism1));

  dramsim3_channel_mem #(.address_mapping_p(2), .channel_select_p(1)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .ch_addr_i(ch_addr_i), .mem_addr_o(mem_addr2),
    .w_v_i(w_v_i), .w_data_i(w_data_i), .rd_v_i(rv2), .rd_mem_addr_i(ra2),
    .data_v_o(data_v2), .data_o(data2), .read_done_ch_addr_o(rdaddr2), .ch_mismatch_o(mism2));

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic [15:0] addr;
    logic        mism;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [16384];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          mon_en = 1'b0;
  logic [31:0] hold_data = '0;
  logic [15:0] hold_addr = '0;

  // Reference address maps, written as plain field concatenations.
  function automatic logic [16:0] map0(input logic [15:0] x, input logic c);
    return {x[15:5], c, x[4:0]};
  endfunction
  function automatic logic [16:0] map1(input logic [15:0] x, input logic c);
    return {c, x};
  endfunction
  function automatic logic [16:0] map2(input logic [15:0] x, input logic c);
    return {x[15:2], c, x[1:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  // Cycle counter; a reset edge returns the held read outputs to zero.
  always @(posedge clk) begin
    cyc++;
    if (!reset_i) begin
      hold_data = '0;
      hold_addr = '0;
    end
  end

  // Monitor: pops an expectation when a response is due, else checks idle/hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("rd_valid",    64'(data_v0), 64'(1));
        chk("rd_data",     64'(data0),   64'(mon_e.data));
        chk("rd_addr",     64'(rdaddr0), 64'(mon_e.addr));
        chk("rd_mismatch", 64'(mism0),   64'(mon_e.mism));
        hold_data = mon_e.data;
        hold_addr = mon_e.addr;
      end else begin
        chk("idle_valid",    64'(data_v0), 64'(0));
        chk("idle_mismatch", 64'(mism0),   64'(0));
        chk("hold_data",     64'(data0),   64'(hold_data));
        chk("hold_addr",     64'(rdaddr0), 64'(hold_addr));
      end
    end
  end

  // One main-instance cycle: drive, push expected read, update model, check maps.
  task automatic cycle(input bit rst, input bit wv, input logic [15:0] wa, input logic [31:0] wd,
                       input bit rv, input logic [15:0] ra, input bit bad_ch);
    @(posedge clk); #1;
    reset_i       = rst ? 1'b0 : 1'b1;
    ch_addr_i     = wa;
    w_v_i         = wv;
    w_data_i      = wd;
    rd_v_i        = rv;
    rd_mem_addr_i = map0(ra, ~bad_ch);
    if (!rst && rv) begin
      exp_t e;
      e.due  = cyc + 1;
      e.data = model[ra[15:2]];
      e.addr = ra;
      e.mism = bad_ch;
      sb.push_back(e);
    end
    if (!rst && wv) model[wa[15:2]] = wd;
    #1;
    chk("map_mode0", 64'(mem_addr0), 64'(map0(wa, 1'b1)));
    chk("map_mode1", 64'(mem_addr1), 64'(map1(wa, 1'b1)));
    chk("map_mode2", 64'(mem_addr2), 64'(map2(wa, 1'b1)));
  endtask

  // Single read on the mode-1 and mode-2 instances, checked directly.
  task automatic rd12(input logic [16:0] a1, input logic [15:0] e1, input bit m1,
                      input logic [16:0] a2, input logic [15:0] e2, input bit m2);
    @(posedge clk); #1;
    rv1 = 1'b1; ra1 = a1;
    rv2 = 1'b1; ra2 = a2;
    @(posedge clk); #1;
    rv1 = 1'b0; rv2 = 1'b0;
    chk("m1_valid",    64'(data_v1), 64'(1));
    chk("m1_addr",     64'(rdaddr1), 64'(e1));
    chk("m1_mismatch", 64'(mism1),   64'(m1));
    chk("m2_valid",    64'(data_v2), 64'(1));
    chk("m2_addr",     64'(rdaddr2), 64'(e2));
    chk("m2_mismatch", 64'(mism2),   64'(m2));
    @(posedge clk); #1;
    chk("m1_idle_valid", 64'(data_v1), 64'(0));
    chk("m2_idle_valid", 64'(data_v2), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16384; i++) model[i] = '0;
    reset_i = 1'b0; ch_addr_i = '0; w_v_i = 1'b0; w_data_i = '0;
    rd_v_i = 1'b0; rd_mem_addr_i = '0;
    rv1 = 1'b0; ra1 = '0; rv2 = 1'b0; ra2 = '0;

    cycle(1, 0, 16'h0, 32'h0, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 32'h0, 0, 16'h0, 0);
    mon_en = 1'b1;

    // Mapping of 0x1234 in all three modes, and round trip through unmap.
    cycle(0, 0, 16'h1234, 32'h0, 0, 16'h0, 0);
    chk("map0_1234", 64'(mem_addr0), 64'(17'h02474));
    chk("map1_1234", 64'(mem_addr1), 64'(17'h11234));
    chk("map2_1234", 64'(mem_addr2), 64'(17'h0246C));
    rd12(17'h11234, 16'h1234, 0, 17'h0246C, 16'h1234, 0);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h1234, 0);

    // Write then read, followed by idle.
    cycle(0, 1, 16'h0010, 32'hDEADBEEF, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0010, 0);
    cycle(0, 0, 16'h0, 32'h0, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 32'h0, 0, 16'h0, 0);

    // Byte offset ignored.
    cycle(0, 1, 16'h0020, 32'hA5A5A5A5, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0023, 0);

    // Read/write collision on the same word, then back-to-back reads.
    cycle(0, 1, 16'h0040, 32'h11111111, 0, 16'h0, 0);
    cycle(0, 1, 16'h0040, 32'h22222222, 1, 16'h0040, 0);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0040, 0);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0010, 0);

    // Channel mismatch on every mode.
    cycle(0, 0, 16'h0, 32'h0, 0, 16'h0, 0);
    rd12(17'h00040, 16'h0040, 1, 17'h00040, 16'h0020, 1);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0040, 1);

    // Never-written word, reset with pending read, write during reset.
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0100, 0);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0010, 0);
    cycle(1, 0, 16'h0, 32'h0, 1, 16'h0010, 0);
    cycle(1, 1, 16'h0010, 32'hBAD0BAD0, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 32'h0, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 32'h0, 1, 16'h0010, 0);

    // Randomized traffic over a small window so reads hit written words.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            16'($urandom_range(0, 255)), $urandom,
            $urandom_range(0, 3) != 0, 16'($urandom_range(0, 255)),
            $urandom_range(0, 7) == 0);
    end

    // Drain with a bounded number of idle cycles.
    for (int n = 0; n < 8 && sb.size() > 0; n++) cycle(0, 0, 16'h0, 32'h0, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 32'h0, 0, 16'h0, 0);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
